// File: rtl/oisc_fifo_pkg.sv
// Shared constants for the oisc8 FIFO port: status register bit positions and pointer sizing.
// OISC_FIFO_LEVEL_EN (optional) enables the level register in the top level.
package oisc_fifo_pkg;

   localparam int ST_TX_FULL  = 0;
   localparam int ST_TX_EMPTY = 1;
   localparam int ST_RX_FULL  = 2;
   localparam int ST_RX_EMPTY = 3;
   localparam int ST_TX_OVF   = 4;
   localparam int ST_RX_UDF   = 5;

   // One extra MSB beyond the address bits distinguishes full from empty.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/oisc_sync_fifo.sv
// Synchronous FIFO with first-word fall-through head (0 when empty); push is ignored when full, pop when empty.
// The occupancy output exists only when OISC_FIFO_LEVEL_EN is defined.
module oisc_sync_fifo
   import oisc_fifo_pkg::*;
#(
   parameter int DWIDTH = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push,
   input  logic [DWIDTH-1:0] i_push_data,
   input  logic              i_pop,
   output logic [DWIDTH-1:0] o_head,
   output logic              o_full,
   output logic              o_empty
`ifdef OISC_FIFO_LEVEL_EN
   ,
   output logic [ptr_width(DEPTH)-1:0] o_count
`endif
);

   localparam int PW = ptr_width(DEPTH);
   localparam int AW = PW - 1;

   logic [DWIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic              w_push_ok;
   logic              w_pop_ok;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push_ok = i_push & ~o_full;
   assign w_pop_ok  = i_pop & ~o_empty;
   assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

`ifdef OISC_FIFO_LEVEL_EN
   assign o_count = r_wr_ptr - r_rd_ptr;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
   end

   // Storage needs no reset: the head is masked to 0 while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
   end

endmodule

// File: rtl/oisc_port_fifo.sv
// oisc8 move-bus port with TX/RX FIFOs, sticky overflow/underflow flags and a status register.
// Define OISC_FIFO_LEVEL_EN to add the {rx_count, tx_count} level register at ADDR_SRC_LVL.
module oisc_port_fifo
   import oisc_fifo_pkg::*;
#(
   parameter int DWIDTH        = 8,
   parameter int DAWIDTH       = 4,
   parameter int SAWIDTH       = 8,
   parameter int DEPTH         = 4,
   parameter int ADDR_DST_DATA = 11,
   parameter int ADDR_SRC_DATA = 33,
   parameter int ADDR_SRC_STAT = 36,
   parameter int ADDR_SRC_LVL  = 37
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               bus_imm,
   input  logic [DAWIDTH-1:0] bus_dst,
   input  logic [SAWIDTH-1:0] bus_src,
   input  logic [DWIDTH-1:0]  bus_data_in,
   output logic [DWIDTH-1:0]  bus_data_out,
   output logic               bus_data_oe,
   output logic [DWIDTH-1:0]  tx_data,
   output logic               tx_valid,
   input  logic               tx_ready,
   input  logic [DWIDTH-1:0]  rx_data,
   input  logic               rx_valid,
   output logic               rx_ready
);

   if (SAWIDTH < DWIDTH || ADDR_SRC_LVL >= (1 << SAWIDTH) ||
       ADDR_DST_DATA >= (1 << DAWIDTH)) begin : g_param_check
      $error("oisc_port_fifo: address or width parameters out of range");
   end

   logic              w_push_req;
   logic [DWIDTH-1:0] w_push_data;
   logic              w_rd_data;
   logic              w_rd_stat;
   logic              w_tx_full;
   logic              w_tx_empty;
   logic              w_rx_full;
   logic              w_rx_empty;
   logic [DWIDTH-1:0] w_rx_head;
   logic              w_tx_ovf_set;
   logic              w_rx_udf_set;
   logic [DWIDTH-1:0] w_status;
   logic              r_tx_ovf;
   logic              r_rx_udf;

   assign w_push_req  = (bus_dst == DAWIDTH'(ADDR_DST_DATA));
   assign w_push_data = bus_imm ? bus_src[DWIDTH-1:0] : bus_data_in;
   assign w_rd_data   = (bus_src == SAWIDTH'(ADDR_SRC_DATA)) & ~bus_imm;
   assign w_rd_stat   = (bus_src == SAWIDTH'(ADDR_SRC_STAT)) & ~bus_imm;

   // Both peripheral sides use valid/ready: a beat transfers at the rising edge where
   // valid and ready are both high; valid never waits on ready, ready only reflects FIFO space.
   assign tx_valid = ~w_tx_empty;
   assign rx_ready = ~w_rx_full;

   assign w_tx_ovf_set = w_push_req & w_tx_full;
   assign w_rx_udf_set = w_rd_data & w_rx_empty;

`ifdef OISC_FIFO_LEVEL_EN
   localparam int HW = DWIDTH / 2;
   localparam int PW = ptr_width(DEPTH);

   logic          w_rd_lvl;
   logic [PW-1:0] w_tx_count;
   logic [PW-1:0] w_rx_count;

   if (PW > HW) begin : g_lvl_width_check
      $error("oisc_port_fifo: FIFO count does not fit in DWIDTH/2 bits");
   end

   assign w_rd_lvl = (bus_src == SAWIDTH'(ADDR_SRC_LVL)) & ~bus_imm;
`endif

   oisc_sync_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_tx_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push_req),
      .i_push_data (w_push_data),
      .i_pop       (tx_ready),
      .o_head      (tx_data),
      .o_full      (w_tx_full),
      .o_empty     (w_tx_empty)
`ifdef OISC_FIFO_LEVEL_EN
      ,
      .o_count     (w_tx_count)
`endif
   );

   oisc_sync_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_rx_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (rx_valid),
      .i_push_data (rx_data),
      .i_pop       (w_rd_data),
      .o_head      (w_rx_head),
      .o_full      (w_rx_full),
      .o_empty     (w_rx_empty)
`ifdef OISC_FIFO_LEVEL_EN
      ,
      .o_count     (w_rx_count)
`endif
   );

   always_comb begin
      w_status              = '0;
      w_status[ST_TX_FULL]  = w_tx_full;
      w_status[ST_TX_EMPTY] = w_tx_empty;
      w_status[ST_RX_FULL]  = w_rx_full;
      w_status[ST_RX_EMPTY] = w_rx_empty;
      w_status[ST_TX_OVF]   = r_tx_ovf;
      w_status[ST_RX_UDF]   = r_rx_udf;
   end

   always_comb begin
      bus_data_oe  = 1'b0;
      bus_data_out = '0;
      if (w_rd_data) begin
         bus_data_oe  = 1'b1;
         bus_data_out = w_rx_head;
      end else if (w_rd_stat) begin
         bus_data_oe  = 1'b1;
         bus_data_out = w_status;
      end
`ifdef OISC_FIFO_LEVEL_EN
      else if (w_rd_lvl) begin
         bus_data_oe  = 1'b1;
         bus_data_out = DWIDTH'({HW'(w_rx_count), HW'(w_tx_count)});
      end
`endif
   end

   // A flag raised in the same cycle as a status read survives the clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tx_ovf <= 1'b0;
         r_rx_udf <= 1'b0;
      end else begin
         r_tx_ovf <= (r_tx_ovf & ~w_rd_stat) | w_tx_ovf_set;
         r_rx_udf <= (r_rx_udf & ~w_rd_stat) | w_rx_udf_set;
      end
   end

endmodule

// File: doc/oisc_port_fifo.md
Name: oisc_port_fifo

Overview:
- Bus-attached dual-FIFO port for the oisc8 move-bus.
- TX path: `mov` to a destination address pushes a byte into the TX FIFO; the peripheral drains it over a valid/ready handshake.
- RX path: the peripheral pushes over valid/ready; a `mov` from a source address pops a byte onto the bus.
- Successor to the single-register port blocks: adds depth, flow control, sticky error flags and a status register. Sits between the bus and COM-style peripherals (UART, SPI).

Parameters:
- DWIDTH, 8, bus data width.
- DAWIDTH, 4, destination address width.
- SAWIDTH, 8, source address width; must be >= DWIDTH.
- DEPTH, 4, entries per FIFO; power of two, >= 2.
- ADDR_DST_DATA, 11, destination address that pushes TX.
- ADDR_SRC_DATA, 33, source address that pops RX.
- ADDR_SRC_STAT, 36, source address that reads status.
- ADDR_SRC_LVL, 37, source address for the level register (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- bus_imm  in  1  instruction immediate flag.
- bus_dst  in  DAWIDTH  instruction destination field.
- bus_src  in  SAWIDTH  instruction source field / immediate value.
- bus_data_in  in  DWIDTH  resolved bus data.
- bus_data_out  out  DWIDTH  data this block drives onto the bus.
- bus_data_oe  out  1  drive enable for bus_data_out; top-level applies tristate.
- tx_data  out  DWIDTH  TX FIFO head.
- tx_valid  out  1  TX FIFO non-empty.
- tx_ready  in  1  peripheral accepts the TX head.
- rx_data  in  DWIDTH  peripheral byte.
- rx_valid  in  1  peripheral byte valid.
- rx_ready  out  1  RX FIFO not full.

Behaviour:
- **Reset** (rst=0, async): both FIFOs empty, pointers 0, sticky flags 0. Outputs are tx_valid=0, rx_ready=1, bus_data_oe=0, bus_data_out=0, tx_data=0.
- **Push decode:** push_req = (bus_dst==ADDR_DST_DATA). Push data = bus_imm ? bus_src[DWIDTH-1:0] : bus_data_in.
- **Push accept:** if push_req and TX not full at the start of the cycle, write at the rising edge.
- **Push to full TX:** the data is dropped and tx_ovf is set. This holds even when the peripheral pops in the same cycle; there is no pass-through.
- **Read decode:** rd_data = (bus_src==ADDR_SRC_DATA) & ~bus_imm, and likewise rd_stat. Reads are always gated by ~bus_imm.
- **Data read:** combinationally, bus_data_oe=1 and bus_data_out = RX head (0 if empty). The pop happens at the rising edge ending the instruction, so latency from decode to bus is 0 cycles.
- **Read of empty RX:** drives 0, sets rx_udf, pointers unchanged.
- **Status read:** drives bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, bit4 tx_ovf, bit5 rx_udf; other bits 0.
  - Both sticky flags clear at the edge ending the status read.
  - A flag set in the same cycle as the clear wins, so it stays 1.
- **TX handshake:** tx_valid = ~tx_empty; tx_data = head, first-word fall-through. tx_valid&tx_ready pops at the edge.
- **RX handshake:** rx_ready = ~rx_full. rx_valid&rx_ready pushes at the edge.
- **Simultaneous push and pop** on a non-full, non-empty FIFO: both occur and the count is unchanged.
- **Pointers:** log2(DEPTH)+1 bits, wrap naturally. Full = MSBs differ and LSBs equal; empty = pointers equal.
- **Address collisions:** push and a read in the same instruction (e.g. `mov COMD, COMDR`) are independent and both execute.
- **Reset mid-transfer:** all contents are discarded and nothing is replayed.

Optional Feature:
- Macro: OISC_FIFO_LEVEL_EN.
- Defined:
  - ADDR_SRC_LVL decodes (gated by ~bus_imm) and drives {rx_count, tx_count}, each in DWIDTH/2 bits, zero-extended.
  - Elaboration-time assertion that log2(DEPTH)+1 <= DWIDTH/2.
  - Counts are the occupancy before that cycle's edge.
- Undefined: ADDR_SRC_LVL is not decoded, bus_data_oe stays 0 for it, and no count logic is instantiated.

Decomposition:
- Package oisc_fifo_pkg: status bit index constants (ST_TX_FULL=0 … ST_RX_UDF=5) and a localparam function for pointer width.
- Sub-module oisc_sync_fifo (DWIDTH, DEPTH): push/pop/full/empty/count/head, instantiated twice (TX, RX).
- The top level holds the bus decode, sticky flags and output mux.

Test Plan:
- Reset, then imm-push 0x11,0x22,0x33,0x44 to ADDR_DST_DATA with tx_ready=0 -> tx_valid=1, tx_data=0x11, status=0x09. Fifth push 0x55 -> dropped, status=0x19. Status read again -> 0x09.
- Raise tx_ready for 4 cycles -> tx_data sequence 0x11,0x22,0x33,0x44, then tx_valid=0, status bit1=1.
- Peripheral pushes 0xA0..0xA3 -> rx_ready falls after the 4th. Four ADDR_SRC_DATA reads return 0xA0..0xA3 with bus_data_oe=1. Fifth read returns 0x00 and status bit5=1.
- Instruction with bus_imm=1, bus_src=ADDR_SRC_DATA -> bus_data_oe=0, RX not popped.
- With TX holding 2 entries, push 0x77 while tx_ready=1 -> count stays 2, order preserved.
- Drop rst mid-burst with 3 TX entries -> tx_valid=0 immediately (async), status=0x0A after release. With OISC_FIFO_LEVEL_EN, ADDR_SRC_LVL reads 0x00.
